cache_controller: RTL

- Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Serves 32-bit word reads and writes from MEM.
- Read hits return data combinationally with no stall.
- Read misses fetch a 64-bit line through the SRAM controller's 4x16 burst; every write is forwarded to SRAM.
- Asserts pause to freeze the pipeline while an SRAM transaction is outstanding.

---
 rtl/cache_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller; read misses fetch a 64-bit line.
module cache_controller #(
   parameter int SETS    = 64,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        pause,
   output logic [31:0] sram_address,
   output logic [31:0] sram_writeData,
   output logic        sram_WR_EN,
   output logic        sram_RD_EN,
   input  logic [63:0] sram_readData,
   input  logic        sram_pause,
   input  logic        sram_ready64
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_MISS = 2'd1,
      WRITE     = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SETS-1:0]  r_valid0;
   logic [SETS-1:0]  r_valid1;
   logic [SETS-1:0]  r_lru;
   logic [TAG_W-1:0] r_tag0  [SETS];
   logic [TAG_W-1:0] r_tag1  [SETS];
   logic [63:0]      r_line0 [SETS];
   logic [63:0]      r_line1 [SETS];

   logic [INDEX_W-1:0] w_index;
   logic [TAG_W-1:0]   w_tag;
   logic               w_off;
   logic [63:0]        w_line0;
   logic [63:0]        w_line1;
   logic               w_hit0;
   logic               w_hit1;
   logic               w_hit;
   logic [31:0]        w_hit_word;
   logic [31:0]        w_fill_word;
   logic               w_victim;
   logic               w_fill;
   logic               w_wr_hit;
   logic               w_lru_touch;

   assign w_index = address[3 +: INDEX_W];
   assign w_tag   = address[3+INDEX_W +: TAG_W];
   assign w_off   = address[2];

   assign w_line0    = r_line0[w_index];
   assign w_line1    = r_line1[w_index];
   assign w_hit0     = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
   assign w_hit1     = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
   assign w_hit      = w_hit0 || w_hit1;
   assign w_hit_word = w_hit1 ? (w_off ? w_line1[63:32] : w_line1[31:0])
                              : (w_off ? w_line0[63:32] : w_line0[31:0]);
   assign w_fill_word = w_off ? sram_readData[63:32] : sram_readData[31:0];

   // Fill empty ways first; only evict by LRU once both ways hold data.
   assign w_victim = !r_valid0[w_index] ? 1'b0 :
                     !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

   assign sram_address   = address;
   assign sram_writeData = writeData;

   always_comb begin
      w_state_nxt = r_state;
      pause       = 1'b0;
      sram_RD_EN  = 1'b1;
      sram_WR_EN  = 1'b1;
      readData    = 32'd0;
      w_fill      = 1'b0;
      w_wr_hit    = 1'b0;
      w_lru_touch = 1'b0;
      if (!rst) begin
         if (w_hit) begin
            readData = w_hit_word;
         end
         case (r_state)
            IDLE: begin
               if (MEM_W_EN) begin
                  w_state_nxt = WRITE;
                  sram_WR_EN  = 1'b0;
                  pause       = 1'b1;
               end else if (MEM_R_EN) begin
                  if (w_hit) begin
                     w_lru_touch = 1'b1;
                  end else begin
                     w_state_nxt = READ_MISS;
                     sram_RD_EN  = 1'b0;
                     pause       = 1'b1;
                  end
               end
            end
            READ_MISS: begin
               sram_RD_EN = 1'b0;
               if (sram_ready64) begin
                  w_state_nxt = IDLE;
                  w_fill      = 1'b1;
                  readData    = w_fill_word;
               end else begin
                  pause = 1'b1;
               end
            end
            WRITE: begin
               sram_WR_EN = 1'b0;
               if (!sram_pause) begin
                  w_state_nxt = IDLE;
                  w_wr_hit    = w_hit;
                  w_lru_touch = w_hit;
               end else begin
                  pause = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_valid0 <= '0;
         r_valid1 <= '0;
         r_lru    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fill) begin
            if (w_victim) begin
               r_valid1[w_index] <= 1'b1;
            end else begin
               r_valid0[w_index] <= 1'b1;
            end
            r_lru[w_index] <= ~w_victim;
         end else if (w_lru_touch) begin
            r_lru[w_index] <= ~w_hit1;
         end
      end
   end

   // Tag and data arrays are qualified by the valid bits, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         if (w_victim) begin
            r_tag1[w_index]  <= w_tag;
            r_line1[w_index] <= sram_readData;
         end else begin
            r_tag0[w_index]  <= w_tag;
            r_line0[w_index] <= sram_readData;
         end
      end else if (w_wr_hit) begin
         if (w_hit1) begin
            if (w_off) begin
               r_line1[w_index][63:32] <= writeData;
            end else begin
               r_line1[w_index][31:0] <= writeData;
            end
         end else begin
            if (w_off) begin
               r_line0[w_index][63:32] <= writeData;
            end else begin
               r_line0[w_index][31:0] <= writeData;
            end
         end
      end
   end

endmodule
